// File: rtl/srt4_arbiter.sv
// Two-port round-robin front end for a shared srt4 divider: sequences begin/inbus,
// captures quotient/remainder from outbus, short-circuits /0 and times out a stalled divider.
module srt4_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_dividend,
  input  logic [7:0] req0_divisor,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic [7:0] resp0_quotient,
  output logic [7:0] resp0_remainder,
  output logic       resp0_err,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_dividend,
  input  logic [7:0] req1_divisor,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp1_quotient,
  output logic [7:0] resp1_remainder,
  output logic       resp1_err,
  output logic       div_begin,
  output logic [7:0] div_inbus,
  input  logic [7:0] div_outbus,
  input  logic       div_end,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_BEGIN, S_LOAD_A, S_LOAD_B, S_WAIT, S_CAPT_R, S_RESP
  } state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       last_grant, grant;
  logic [7:0] dividend_q, divisor_q, quot_q, rem_q, wd_q;
  logic       err_q;
  logic       sel0, sel1, resp_ack;
  logic [7:0] in_dividend, in_divisor;

  // On contention the port that did not win last time goes first.
  assign sel0 = req0_valid && (!req1_valid || last_grant);
  assign sel1 = req1_valid && (!req0_valid || !last_grant);
  assign in_dividend = sel1 ? req1_dividend : req0_dividend;
  assign in_divisor  = sel1 ? req1_divisor  : req0_divisor;

  assign req0_ready = (state == S_IDLE) && sel0;
  assign req1_ready = (state == S_IDLE) && sel1;
  assign busy       = (state != S_IDLE);

  assign resp0_valid     = (state == S_RESP) && !grant;
  assign resp1_valid     = (state == S_RESP) && grant;
  assign resp0_err       = resp0_valid && err_q;
  assign resp1_err       = resp1_valid && err_q;
  assign resp0_quotient  = quot_q;
  assign resp1_quotient  = quot_q;
  assign resp0_remainder = rem_q;
  assign resp1_remainder = rem_q;
  assign resp_ack        = grant ? resp1_ready : resp0_ready;

  // div_begin/div_inbus are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      wd_q       <= '0;
      div_begin  <= 1'b0;
      div_inbus  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel0 || sel1) begin
            grant      <= sel1;
            last_grant <= sel1;
            dividend_q <= in_dividend;
            divisor_q  <= in_divisor;
            if (in_divisor == 8'd0) begin
              err_q  <= 1'b1;
              quot_q <= 8'hFF;
              rem_q  <= in_dividend;
              state  <= S_RESP;
            end else begin
              err_q     <= 1'b0;
              div_begin <= 1'b1;
              state     <= S_BEGIN;
            end
          end
        end
        S_BEGIN: begin
          div_begin <= 1'b0;
          div_inbus <= dividend_q;
          state     <= S_LOAD_A;
        end
        S_LOAD_A: begin
          div_inbus <= divisor_q;
          state     <= S_LOAD_B;
        end
        S_LOAD_B: begin
          div_inbus <= '0;
          wd_q      <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (div_end) begin
            quot_q <= div_outbus;
            state  <= S_CAPT_R;
          end else if (wd_q == WD_LAST) begin
            err_q  <= 1'b1;
            quot_q <= '0;
            rem_q  <= '0;
            state  <= S_RESP;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        S_CAPT_R: begin
          rem_q <= div_outbus;
          state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ack) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_srt4_arbiter.sv
// Bench for srt4_arbiter: transaction-level model with a divider stand-in, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_srt4_arbiter;
  localparam int TO = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic       resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
  logic [7:0] resp0_quotient, resp0_remainder, resp1_quotient, resp1_remainder;
  logic       div_begin, div_end, busy;
  logic [7:0] div_inbus, div_outbus;

  srt4_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_quotient(resp0_quotient), .resp0_remainder(resp0_remainder), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_quotient(resp1_quotient), .resp1_remainder(resp1_remainder), .resp1_err(resp1_err),
    .div_begin(div_begin), .div_inbus(div_inbus), .div_outbus(div_outbus), .div_end(div_end),
    .busy(busy)
  );

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // stimulus knobs read by the model when a job is accepted
  int end_delay_sel = -1;
  bit force_to = 0;
  bit mon_en = 0;
  int ready_mode = 0;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: begin resp0_ready = 1'b1; resp1_ready = 1'b1; end
      1: begin resp0_ready = 1'b0; resp1_ready = 1'b0; end
      default: begin resp0_ready = 1'($urandom); resp1_ready = 1'($urandom); end
    endcase
  end

  // Model: one job in flight, timed as offsets from the accepting cycle.
  bit         m_active = 0, m_lg = 1, m_port = 0, m_div0 = 0, m_err = 0;
  int         m_hs = 0, m_end_dt = -1, m_resp_dt = 0, cyc = 0;
  logic [7:0] m_a = 0, m_b = 0, m_q = 0, m_r = 0;

  initial begin div_end = 1'b0; div_outbus = 8'd0; end

  always @(negedge clk) begin
    int dt, dly;
    bit e_r0, e_r1, e_v, e_beg, quiet;
    logic [7:0] e_in;
    logic [31:0] ev, av;
    cyc++;
    dt   = cyc - m_hs;
    e_r0 = !m_active && req0_valid && (!req1_valid || m_lg);
    e_r1 = !m_active && req1_valid && (!req0_valid || !m_lg);
    e_v  = m_active && (dt >= m_resp_dt);
    e_beg = m_active && !m_div0 && dt == 1;
    e_in = (m_active && !m_div0 && dt == 2) ? m_a :
           (m_active && !m_div0 && dt == 3) ? m_b : 8'd0;
    ev = {m_active, e_r0, e_r1, e_beg, e_in, e_v && !m_port, e_v && m_port,
          e_v && m_err && !m_port, e_v && m_err && m_port,
          e_v ? m_q : 8'd0, e_v ? m_r : 8'd0};
    av = {busy, req0_ready, req1_ready, div_begin, div_inbus, resp0_valid, resp1_valid,
          resp0_err, resp1_err,
          resp1_valid ? resp1_quotient : resp0_valid ? resp0_quotient : 8'd0,
          resp1_valid ? resp1_remainder : resp0_valid ? resp0_remainder : 8'd0};
    if (mon_en) chk($sformatf("cycle%0d", cyc), av, ev);

    if (rst_b) begin
      m_active = 0; m_lg = 1;
    end else if (!m_active && (e_r0 || e_r1)) begin
      m_active = 1; m_hs = cyc; m_port = e_r1; m_lg = e_r1;
      m_a = e_r1 ? req1_dividend : req0_dividend;
      m_b = e_r1 ? req1_divisor : req0_divisor;
      if (m_b == 0) begin
        m_div0 = 1; m_err = 1; m_q = 8'hFF; m_r = m_a; m_resp_dt = 1; m_end_dt = -1;
      end else begin
        m_div0 = 0;
        dly = force_to ? 1000 : (end_delay_sel >= 0 ? end_delay_sel : int'($urandom_range(0, 8)));
        if (dly < TO) begin
          m_end_dt = 4 + dly; m_resp_dt = m_end_dt + 2; m_err = 0; m_q = m_a / m_b; m_r = m_a % m_b;
        end else begin
          m_end_dt = -1; m_resp_dt = 4 + TO; m_err = 1; m_q = 0; m_r = 0;
        end
      end
    end else if (e_v && (m_port ? resp1_ready : resp0_ready)) begin
      m_active = 0;
    end

    // Divider stand-in; spurious div_end is injected wherever it must be ignored.
    dt = cyc - m_hs;
    if (m_active && m_end_dt >= 0 && dt == m_end_dt) begin
      div_end = 1'b1; div_outbus = m_q;
    end else if (m_active && m_end_dt >= 0 && dt == m_end_dt + 1) begin
      div_end = 1'($urandom); div_outbus = m_r;
    end else begin
      quiet = m_active && !m_div0 && dt >= 4 && (m_end_dt >= 0 ? dt < m_end_dt : dt < 4 + TO);
      div_end = !quiet && ($urandom_range(0, 7) == 0);
      div_outbus = 8'($urandom);
    end
  end

  task automatic send(input int p, input logic [7:0] a, input logic [7:0] b, output time t_hs);
    bit ok = 0;
    if (p == 0) begin req0_valid = 1; req0_dividend = a; req0_divisor = b; end
    else        begin req1_valid = 1; req1_dividend = a; req1_divisor = b; end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
    end
    t_hs = $time;
    chk($sformatf("send%0d_handshake", p), ok, 1);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_resp(input int p, output int lat, output logic [7:0] q, output logic [7:0] r,
                           output logic e);
    bit ok = 0;
    lat = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk); lat++;
      ok = p ? resp1_valid : resp0_valid;
    end
    chk($sformatf("resp%0d_seen", p), ok, 1);
    q = p ? resp1_quotient : resp0_quotient;
    r = p ? resp1_remainder : resp0_remainder;
    e = p ? resp1_err : resp0_err;
    ok = p ? (resp1_valid && resp1_ready) : (resp0_valid && resp0_ready);
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = p ? (resp1_valid && resp1_ready) : (resp0_valid && resp0_ready);
    end
    chk($sformatf("resp%0d_consumed", p), ok, 1);
  endtask

  task automatic check_res(input string n, input int lat, input logic [7:0] q, input logic [7:0] r,
                           input logic e, input int xlat, input int xq, input int xr, input int xe);
    if (xlat > 0) chk({n, "_latency"}, lat, xlat);
    chk({n, "_quotient"}, q, xq);
    chk({n, "_remainder"}, r, xr);
    chk({n, "_err"}, e, xe);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: run did not finish, %0d/%0d passed so far", n_pass, n_chk);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int l0, l1;
    logic [7:0] q0, r0, q1, r1, a0, b0, a1, b1;
    logic e0, e1;
    time t0, t1;
    bit ok;
    int mode;

    rst_b = 1; req0_valid = 0; req1_valid = 0;
    req0_dividend = 0; req0_divisor = 0; req1_dividend = 0; req1_divisor = 0;
    repeat (3) @(posedge clk);
    #1 rst_b = 0; mon_en = 1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_resp_valid", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 0);
    chk("reset_div_drive", {div_begin, div_inbus}, 0);
    chk("reset_result_regs", {resp0_quotient, resp0_remainder}, 0);

    // contention: port 0 wins first after reset, and again after port 1 was last
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      a0 = k ? 8'd77 : 8'd200; b0 = k ? 8'd7 : 8'd9;
      a1 = k ? 8'd13 : 8'd50;  b1 = k ? 8'd2 : 8'd5;
      fork
        begin send(0, a0, b0, t0); wait_resp(0, l0, q0, r0, e0); end
        begin send(1, a1, b1, t1); wait_resp(1, l1, q1, r1, e1); end
      join
      chk($sformatf("contention%0d_port0_first", k), t0 < t1, 1);
      check_res($sformatf("contention%0d_p0", k), l0, q0, r0, e0, 0, k ? 11 : 22, k ? 0 : 2, 0);
      check_res($sformatf("contention%0d_p1", k), l1, q1, r1, e1, 0, k ? 6 : 10, k ? 1 : 0, 0);
    end

    end_delay_sel = 0;
    send(0, 8'd100, 8'd7, t0); wait_resp(0, l0, q0, r0, e0);
    check_res("single", l0, q0, r0, e0, 6, 14, 2, 0);

    send(1, 8'd200, 8'd0, t0); wait_resp(1, l0, q0, r0, e0);
    check_res("div0", l0, q0, r0, e0, 1, 8'hFF, 8'hC8, 1);

    force_to = 1;
    send(0, 8'd123, 8'd4, t0); wait_resp(0, l0, q0, r0, e0);
    check_res("timeout", l0, q0, r0, e0, 4 + TO, 0, 0, 1);
    force_to = 0; end_delay_sel = -1;
    repeat (4) @(posedge clk);
    #1 send(1, 8'd45, 8'd6, t0); wait_resp(1, l0, q0, r0, e0);
    check_res("after_timeout", l0, q0, r0, e0, 0, 7, 3, 0);

    // div_end on the last watchdog cycle still wins; one cycle later it is too late
    end_delay_sel = TO - 1;
    send(0, 8'd250, 8'd3, t0); wait_resp(0, l0, q0, r0, e0);
    check_res("end_at_limit", l0, q0, r0, e0, TO + 5, 83, 1, 0);
    end_delay_sel = TO;
    send(0, 8'd250, 8'd3, t0); wait_resp(0, l0, q0, r0, e0);
    check_res("end_past_limit", l0, q0, r0, e0, 4 + TO, 0, 0, 1);

    end_delay_sel = 2;
    @(posedge clk); #1 ready_mode = 1;
    send(0, 8'd30, 8'd4, t0);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); ok = resp0_valid; end
    chk("bp_resp_seen", ok, 1);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1; req0_divisor = 8'd3; req1_divisor = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", {req0_ready, req1_ready}, 0);
      chk("bp_busy", busy, 1);
      chk("bp_resp_hold", {resp0_valid, resp1_valid, resp0_err, resp0_quotient, resp0_remainder},
          {1'b1, 1'b0, 1'b0, 8'd7, 8'd2});
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0; ready_mode = 0;
    @(negedge clk);
    chk("bp_release", resp0_valid && resp0_ready, 1);
    @(negedge clk);
    chk("bp_idle_next", busy, 0);

    force_to = 1;
    send(0, 8'd99, 8'd9, t0);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 rst_b = 1;
    @(posedge clk); #1 rst_b = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 0);
    chk("midrst_div_drive", {div_begin, div_inbus}, 0);
    chk("midrst_result_regs", {resp0_quotient, resp0_remainder}, 0);
    force_to = 0; end_delay_sel = -1;
    repeat (TO + 6) @(posedge clk);
    #1 send(0, 8'd9, 8'd3, t0); wait_resp(0, l0, q0, r0, e0);
    check_res("after_reset", l0, q0, r0, e0, 0, 3, 0, 0);

    // randomized traffic; the per-cycle compare carries the checking
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      mode = $urandom_range(0, 2);
      force_to = ($urandom_range(0, 9) == 0);
      a0 = 8'($urandom); b0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      a1 = 8'($urandom); b1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      fork
        begin if (mode != 1) send(0, a0, b0, t0); end
        begin if (mode != 0) send(1, a1, b1, t1); end
      join
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin @(posedge clk); ok = !m_active; end
      chk($sformatf("rand%0d_drained", n), ok, 1);
    end
    ready_mode = 0; force_to = 0;
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
